store_drain_ctrl: RTL and testbench

STORE_DRAIN_CTRL -- requirements
Module: store_drain_ctrl

---
 rtl/store_drain_ctrl.sv | 132 +++++++++++++
 tb/tb_store_drain_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_ctrl.sv
// rtl/store_drain_ctrl.sv - drains committed stores from the store queue into D-cache write requests
module store_drain_ctrl #(
    parameter int ADDRESS_SIZE    = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      halt_i,
    input  logic                      sq_valid_i,
    input  logic [ADDRESS_SIZE-1:0]   sq_paddr_i,
    input  logic [DATA_WIDTH-1:0]     sq_data_i,
    input  logic [DATA_WIDTH/8-1:0]   sq_be_i,
    output logic                      sq_pop_o,
    output logic                      req_o,
    output logic [ADDRESS_SIZE-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    output logic [DATA_WIDTH/8-1:0]   be_o,
    input  logic                      gnt_i,
    input  logic                      rvalid_i,
    output logic                      no_st_pending_o,
    output logic                      resp_err_o,
    output logic [31:0]               drained_cnt_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int OW       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW:0] MAX_EXT = (OW + 1)'(MAX_OUTSTANDING);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [OW-1:0]  outst_q;
    logic [OW:0]    outst_proj;
    logic           grant;
    logic           ack_ok;
    logic           ack_bad;
    logic           issue_ok;
    logic           latch_en;

    assign grant   = (state_q == S_REQ) && gnt_i;
    assign ack_ok  = rvalid_i && (outst_q != '0);
    assign ack_bad = rvalid_i && (outst_q == '0);

    // Outstanding count as it will be after this edge; the new grant is counted
    // so a back-to-back latch can never push the count past the limit.
    assign outst_proj = {1'b0, outst_q}
                      + {{OW{1'b0}}, grant}
                      - {{OW{1'b0}}, ack_ok};

    assign issue_ok = sq_valid_i && !halt_i && (outst_proj < MAX_EXT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue_ok) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (gnt_i && !issue_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        latch_en = 1'b0;
        req_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                latch_en = issue_ok;
            end
            S_REQ: begin
                req_o    = 1'b1;
                latch_en = gnt_i && issue_ok;
            end
            default: begin
                latch_en = 1'b0;
                req_o    = 1'b0;
            end
        endcase
    end

    // The pop is combinational, so it is masked while reset is held.
    assign sq_pop_o = latch_en && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_o  <= '0;
            wdata_o <= '0;
            be_o    <= {BE_WIDTH{1'b0}};
        end else if (latch_en) begin
            addr_o  <= sq_paddr_i;
            wdata_o <= sq_data_i;
            be_o    <= sq_be_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q       <= '0;
            drained_cnt_o <= '0;
            resp_err_o    <= 1'b0;
        end else begin
            outst_q <= outst_proj[OW-1:0];
            if (ack_ok) begin
                drained_cnt_o <= drained_cnt_o + 32'd1;
            end
            if (ack_bad) begin
                resp_err_o <= 1'b1;
            end
        end
    end

    assign no_st_pending_o = !sq_valid_i && (state_q == S_IDLE) && (outst_q == '0);

endmodule

// File: tb/tb_store_drain_ctrl.sv
// tb/tb_store_drain_ctrl.sv - self-checking bench for store_drain_ctrl
module tb_store_drain_ctrl;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int BW   = DW / 8;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          halt;
    logic          sq_valid;
    logic [AW-1:0] sq_paddr;
    logic [DW-1:0] sq_data;
    logic [BW-1:0] sq_be;
    logic          sq_pop;
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic          gnt;
    logic          rvalid;
    logic          no_st_pending;
    logic          resp_err;
    logic [31:0]   drained_cnt;

    always #5 clk = ~clk;

    store_drain_ctrl #(
        .ADDRESS_SIZE    (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .halt_i          (halt),
        .sq_valid_i      (sq_valid),
        .sq_paddr_i      (sq_paddr),
        .sq_data_i       (sq_data),
        .sq_be_i         (sq_be),
        .sq_pop_o        (sq_pop),
        .req_o           (req),
        .addr_o          (addr),
        .wdata_o         (wdata),
        .be_o            (be),
        .gnt_i           (gnt),
        .rvalid_i        (rvalid),
        .no_st_pending_o (no_st_pending),
        .resp_err_o      (resp_err),
        .drained_cnt_o   (drained_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, want);
    endtask

    task automatic clear_inputs();
        halt = 1'b0; sq_valid = 1'b0; sq_paddr = '0; sq_data = '0; sq_be = '0;
        gnt = 1'b0; rvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle of hand stimulus: drive after the falling edge, settle, then checks follow.
    task automatic cyc(input logic v, input logic [63:0] a, input logic g, input logic r, input logic h);
        @(negedge clk);
        sq_valid = v; sq_paddr = a; sq_data = 64'hDEADBEEF; sq_be = 8'h0F;
        gnt = g; rvalid = r; halt = h;
        #1;
    endtask

    typedef struct {
        logic        halt, sqv, gnt, rv;
        logic        pop, req, nsp;
        int unsigned dr;
    } vec_t;
    vec_t vecs[12];

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  b;
    } st_t;
    st_t q[$];

    logic [63:0] held_addr;
    int rem, grants, pops;

    task automatic tput_cycles(input int n, input logic rv_first);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            sq_valid = (rem > 0); sq_paddr = 64'h1000 + 64'(rem);
            sq_data = 64'h0; sq_be = 8'hFF; halt = 1'b0;
            gnt = 1'b1; rvalid = rv_first && (c == 0);
            #1;
            if (req) grants++;
            if (sq_pop) begin pops++; rem--; end
        end
    endtask

    initial begin
        // ---- reset state ----
        rst_n = 1'b0;
        clear_inputs();
        sq_valid = 1'b1;
        #3;
        chk("rst_req", req, 0);
        chk("rst_pop", sq_pop, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_be", be, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_drained", drained_cnt, 0);
        chk("rst_nsp_v1", no_st_pending, 0);
        sq_valid = 1'b0;
        #1;
        chk("rst_nsp_v0", no_st_pending, 1);
        rst_n = 1'b1;
        do_reset();

        // ---- table: single store then halt interaction ----
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].sqv, 64'h80001000, vecs[i].gnt, vecs[i].rv, vecs[i].halt);
            chk($sformatf("vec%0d_pop", i), sq_pop, vecs[i].pop);
            chk($sformatf("vec%0d_req", i), req, vecs[i].req);
            chk($sformatf("vec%0d_nsp", i), no_st_pending, vecs[i].nsp);
            chk($sformatf("vec%0d_drained", i), drained_cnt, 64'(vecs[i].dr));
            if (vecs[i].req) begin
                chk($sformatf("vec%0d_addr", i), addr, 64'h80001000);
                chk($sformatf("vec%0d_wdata", i), wdata, 64'hDEADBEEF);
                chk($sformatf("vec%0d_be", i), be, 8'h0F);
            end
        end

        // ---- backpressure: request held for 6 cycles ----
        do_reset();
        cyc(1, 64'h80002000, 0, 0, 0);
        chk("bp_pop", sq_pop, 1);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 64'h80003000 + 64'(k), (k == 5), 0, 1);
            chk($sformatf("bp%0d_req", k), req, 1);
            chk($sformatf("bp%0d_addr", k), addr, 64'h80002000);
            chk($sformatf("bp%0d_pop", k), sq_pop, 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("bp_after_req", req, 0);

        // ---- throughput limit ----
        do_reset();
        rem = 4; grants = 0; pops = 0;
        tput_cycles(10, 1'b0);
        chk("tp_grants2", 64'(grants), 2);
        chk("tp_idle_req", req, 0);
        tput_cycles(8, 1'b1);
        chk("tp_grants3", 64'(grants), 3);
        tput_cycles(8, 1'b1);
        chk("tp_grants4", 64'(grants), 4);
        chk("tp_pops4", 64'(pops), 4);

        // ---- simultaneous grant and acknowledge ----
        do_reset();
        cyc(1, 64'hA0, 0, 0, 0);
        chk("sim_pop0", sq_pop, 1);
        cyc(1, 64'hA8, 1, 0, 0);
        chk("sim_pop1", sq_pop, 1);
        chk("sim_addr0", addr, 64'hA0);
        cyc(1, 64'hB0, 1, 1, 0);
        chk("sim_pop2", sq_pop, 1);
        chk("sim_addr1", addr, 64'hA8);
        cyc(0, 0, 0, 0, 0);
        chk("sim_req2", req, 1);
        chk("sim_addr2", addr, 64'hB0);
        chk("sim_pop_none", sq_pop, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("sim_drained3", drained_cnt, 3);
        chk("sim_err0", resp_err, 0);
        chk("sim_nsp", no_st_pending, 1);

        // ---- spurious acknowledge and asynchronous reset mid-request ----
        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("sp_err", resp_err, 1);
        chk("sp_drained", drained_cnt, 0);
        chk("sp_nsp", no_st_pending, 1);
        cyc(1, 64'hC0, 0, 0, 0);
        chk("sp_pop", sq_pop, 1);
        cyc(1, 64'hC8, 0, 0, 0);
        chk("sp_err_sticky", resp_err, 1);
        chk("ar_req_before", req, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_req", req, 0);
        chk("ar_pop", sq_pop, 0);
        chk("ar_addr", addr, 0);
        chk("ar_wdata", wdata, 0);
        chk("ar_be", be, 0);
        chk("ar_err", resp_err, 0);
        chk("ar_drained", drained_cnt, 0);
        chk("ar_nsp", no_st_pending, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();

        // ---- randomized run against a behavioural model ----
        do_reset();
        q.delete();
        begin
            bit          m_lat;
            st_t         m_reg;
            int          m_out;
            int unsigned m_dr;
            bit          pend_pop;
            bit          granted, acked, can;
            m_lat = 0; m_out = 0; m_dr = 0; pend_pop = 0;
            m_reg = '{64'h0, 64'h0, 8'h0};
            for (int cy = 0; cy < 3000; cy++) begin
                @(negedge clk);
                if (pend_pop) void'(q.pop_front());
                pend_pop = 0;
                if ($urandom_range(0, 2) == 0 && q.size() < 6)
                    q.push_back('{{$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom)});
                sq_valid = (q.size() > 0);
                if (q.size() > 0) begin
                    sq_paddr = q[0].a; sq_data = q[0].d; sq_be = q[0].b;
                end else begin
                    sq_paddr = {$urandom, $urandom}; sq_data = '0; sq_be = '0;
                end
                gnt    = 1'($urandom_range(0, 1));
                halt   = ($urandom_range(0, 9) == 0);
                rvalid = (m_out > 0) && ($urandom_range(0, 2) == 0);
                #1;
                granted = m_lat && gnt;
                acked   = rvalid && (m_out > 0);
                can     = (q.size() > 0) && !halt
                          && ((m_out + int'(granted) - int'(acked)) < MAXO)
                          && (!m_lat || granted);
                chk("rnd_pop", sq_pop, can);
                chk("rnd_req", req, m_lat);
                chk("rnd_nsp", no_st_pending, (q.size() == 0) && !m_lat && (m_out == 0));
                chk("rnd_drained", drained_cnt, 64'(m_dr));
                chk("rnd_err", resp_err, 0);
                if (m_lat) begin
                    chk("rnd_addr", addr, m_reg.a);
                    chk("rnd_wdata", wdata, m_reg.d);
                    chk("rnd_be", be, m_reg.b);
                end
                m_out = m_out + int'(granted) - int'(acked);
                if (acked) m_dr++;
                if (granted) m_lat = 0;
                if (can) begin
                    m_lat = 1; m_reg = q[0]; pend_pop = 1;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
